skolem_witness_check: RTL and testbench
=======================================

Name: skolem_witness_check

Overview:
- Sequential harness stage sitting directly downstream of a combinational Skolem-function netlist for the bvult/bvmul invertibility condition, i.e. the existence of x such that bvult(bvmul(x,s),t).
- Queries the Skolem function one bit per cycle, LSB first, and assembles the witness x.
- Recomputes x*s mod 2^W with a shift-add multiplier, compares the product against t, and reports whether the witness satisfies the constraint.
- Also reports the invertibility condition (t != 0) and an error whenever the condition holds but the witness fails.

Parameters:
- W, 4, operand/witness bit width (W >= 2).
- IW, $clog2(W), width of sk_idx.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new check; accepted only in IDLE.
- s  in  W  multiplicand operand; latched on accepted start.
- t  in  W  bound operand; latched on accepted start.
- sk_bit  in  1  Skolem-function output for bit sk_idx; sampled same cycle as sk_req.
- sk_req  out  1  high while querying the Skolem function.
- sk_idx  out  IW  witness bit currently queried.
- x_part  out  W  witness bits decided so far; undecided bits are 0.
- busy  out  1  high in COLLECT and MUL.
- done  out  1  one-cycle pulse when results become valid.
- x  out  W  assembled witness.
- prod  out  W  (x*s) mod 2^W.
- ok  out  1  prod < t, unsigned.
- ic  out  1  invertibility condition, t != 0.
- err  out  1  ic & ~ok.

Behaviour:
- Reset: state=IDLE; every output 0 (sk_req, sk_idx, x_part, busy, done, x, prod, ok, ic, err). Internal s/t/accumulator registers cleared.
- FSM states: IDLE -> COLLECT -> MUL -> DONE -> IDLE.
- IDLE:
  - On start=1: latch s and t, clear x and the accumulator, set idx=0, go to COLLECT.
  - On start=0: stay. Result outputs hold their last values.
- COLLECT (W cycles):
  - sk_req=1, sk_idx=idx, busy=1.
  - Each cycle sets x[idx]=sk_bit; x_part reflects the update from the next cycle.
  - idx increments. After the cycle with idx=W-1, go to MUL.
- MUL (W cycles):
  - busy=1, sk_req=0.
  - Cycle j: if x[j], acc += (s << j), truncated to W bits. Arithmetic is modulo 2^W; carries beyond bit W-1 are discarded.
  - After j=W-1, go to DONE.
- DONE (1 cycle):
  - prod=acc; ok=(acc<t); ic=(t!=0); err=ic&~ok; done=1; busy=0.
  - Next state is IDLE. Results hold until the next accepted start clears them.
- Latency: start sampled in cycle 0 -> done high in cycle 2W+1 (cycle 9 for W=4).
- start while busy or in DONE: ignored; no restart, no queueing.
- s/t changing after acceptance: no effect, because latched copies are used.
- rst mid-operation (any state): takes priority over everything. Next cycle is IDLE with all outputs 0; a partial witness is discarded with no done pulse.
- t=0: ok=0 necessarily; ic=0 so err=0.
- sk_bit is treated as combinationally valid in the same cycle as sk_req. The block never waits on it.

Optional Feature:
- Macro SKW_STICKY_ERR_EN.
- Defined:
  - Adds output err_sticky (1 bit), set in the DONE cycle whenever err=1.
  - Cleared only by rst; unaffected by subsequent passing checks.
- Undefined:
  - Port and register absent; err reflects only the latest check.

Test Plan:
- W=4, rst held 2 cycles -> all outputs 0, state IDLE; start then accepted in the cycle after rst drops.
- s=3, t=5, sk_bit sequence 1,0,0,0 -> sk_idx 0..3 across cycles 1-4; done in cycle 9 with x=1, prod=3, ok=1, ic=1, err=0.
- s=5, t=2, sk bits 1,0,0,0 -> x=1, prod=5, ok=0, ic=1, err=1. With SKW_STICKY_ERR_EN, err_sticky stays 1 after a following passing run (s=3, t=5, x=1).
- s=15, t=2, sk bits 1,1,1,1 -> x=15, prod=1 (225 mod 16), ok=1, ic=1, err=0 (wrap-around check).
- s=3, t=0, any bits -> ok=0, ic=0, err=0. A start pulsed in cycles 3 and 7 of this run is ignored: exactly one done.
- s=3, t=5, rst asserted in cycle 2 of COLLECT -> next cycle busy=0, sk_req=0, x_part=0, no done. A fresh start then completes normally with done in cycle 9.

Source files
------------

// File: rtl/skolem_witness_check_if.sv
// Handshake and result bundle between a Skolem-function netlist and its witness checker.
// With SKW_STICKY_ERR_EN defined, the bundle also carries err_sticky.
interface skolem_witness_check_if #(
    parameter int W  = 4,
    parameter int IW = $clog2(W)
);
    logic          start;
    logic [W-1:0]  s;
    logic [W-1:0]  t;
    logic          sk_bit;
    logic          sk_req;
    logic [IW-1:0] sk_idx;
    logic [W-1:0]  x_part;
    logic          busy;
    logic          done;
    logic [W-1:0]  x;
    logic [W-1:0]  prod;
    logic          ok;
    logic          ic;
    logic          err;
`ifdef SKW_STICKY_ERR_EN
    logic          err_sticky;

    modport master (
        output start, s, t, sk_bit,
        input  sk_req, sk_idx, x_part, busy, done, x, prod, ok, ic, err, err_sticky
    );
    modport slave (
        input  start, s, t, sk_bit,
        output sk_req, sk_idx, x_part, busy, done, x, prod, ok, ic, err, err_sticky
    );
`else
    modport master (
        output start, s, t, sk_bit,
        input  sk_req, sk_idx, x_part, busy, done, x, prod, ok, ic, err
    );
    modport slave (
        input  start, s, t, sk_bit,
        output sk_req, sk_idx, x_part, busy, done, x, prod, ok, ic, err
    );
`endif
endinterface

// File: rtl/skolem_witness_check.sv
// Collects a Skolem witness bit-serially, recomputes x*s mod 2^W by shift-add and checks it against t.
// Optional macro SKW_STICKY_ERR_EN adds a reset-cleared sticky error flag.
module skolem_witness_check #(
    parameter int W  = 4,
    parameter int IW = $clog2(W)
) (
    input  logic                    clk,
    input  logic                    rst,
    skolem_witness_check_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, MUL, DONE} state_t;

    typedef struct packed {
        logic [W-1:0] prod;
        logic         ok;
        logic         ic;
        logic         err;
    } result_t;

    state_t        state, state_nxt;
    logic [IW-1:0] idx;
    logic [W-1:0]  s_q, t_q, x_q, acc;
    logic [W-1:0]  partial, acc_nxt;
    result_t       res, res_nxt;
    logic          last;

    assign last = (idx == IW'(W - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = COLLECT;
            COLLECT: if (last)      state_nxt = MUL;
            MUL:     if (last)      state_nxt = DONE;
            DONE:                   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // In MUL, idx doubles as the multiplier bit position j.
    always_comb begin
        partial     = x_q[idx] ? (s_q << idx) : '0;
        acc_nxt     = acc + partial;
        res_nxt     = '0;
        res_nxt.prod = acc_nxt;
        res_nxt.ok  = (acc_nxt < t_q);
        res_nxt.ic  = (t_q != '0);
        res_nxt.err = res_nxt.ic & ~res_nxt.ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
            s_q <= '0;
            t_q <= '0;
            x_q <= '0;
            acc <= '0;
            res <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        s_q <= bus.s;
                        t_q <= bus.t;
                        x_q <= '0;
                        acc <= '0;
                        idx <= '0;
                        res <= '0;
                    end
                end
                COLLECT: begin
                    x_q[idx] <= bus.sk_bit;
                    idx      <= last ? '0 : idx + IW'(1);
                end
                MUL: begin
                    acc <= acc_nxt;
                    idx <= last ? '0 : idx + IW'(1);
                    // Results land at the edge into DONE so they are valid alongside done.
                    if (last) res <= res_nxt;
                end
                default: ;
            endcase
        end
    end

`ifdef SKW_STICKY_ERR_EN
    logic err_sticky_q;

    always_ff @(posedge clk) begin
        if (rst)                                   err_sticky_q <= 1'b0;
        else if (state == MUL && last && res_nxt.err) err_sticky_q <= 1'b1;
    end

    assign bus.err_sticky = err_sticky_q;
`endif

    assign bus.sk_req = (state == COLLECT);
    assign bus.sk_idx = (state == COLLECT) ? idx : '0;
    assign bus.x_part = x_q;
    assign bus.x      = x_q;
    assign bus.busy   = (state == COLLECT) || (state == MUL);
    assign bus.done   = (state == DONE);
    assign bus.prod   = res.prod;
    assign bus.ok     = res.ok;
    assign bus.ic     = res.ic;
    assign bus.err    = res.err;
endmodule

// File: tb/tb_skolem_witness_check.sv
// Self-checking bench for skolem_witness_check: directed table, randomized runs against a model, reset corners.
module tb_skolem_witness_check;
    localparam int W  = 4;
    localparam int IW = $clog2(W);

    typedef struct {
        logic [W-1:0] s, t, bits;
        logic [15:0]  pulses;
        logic [W-1:0] x, prod;
        logic         ok, ic, err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   err_cnt = 0;
    int   chk_cnt = 0;
    vec_t tbl[8];

    skolem_witness_check_if #(.W(W), .IW(IW)) bus();

    skolem_witness_check #(.W(W), .IW(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: witness is the Skolem bit sequence; product wraps modulo 2^W.
    function automatic vec_t model(input logic [W-1:0] s, t, bits, input logic [15:0] pulses);
        vec_t v;
        int   p;
        p        = (int'(bits) * int'(s)) % (1 << W);
        v.s      = s;
        v.t      = t;
        v.bits   = bits;
        v.pulses = pulses;
        v.x      = bits;
        v.prod   = p[W-1:0];
        v.ok     = (p < int'(t));
        v.ic     = (t != 0);
        v.err    = v.ic && !v.ok;
        return v;
    endfunction

    task automatic run(input vec_t v, input string tag);
        int           done_n, done_c, m;
        logic [W-1:0] cx, cp;
        logic         cok, cic, cerr;
        done_n = 0; done_c = 0; cx = '0; cp = '0; cok = 0; cic = 0; cerr = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.s     = v.s;
        bus.t     = v.t;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.s     = W'($urandom);
        bus.t     = W'($urandom);
        for (int c = 1; c <= 2 * W + 3; c++) begin
            bus.start = v.pulses[c];
            if (c <= W) begin
                m = (1 << (c - 1)) - 1;
                check({tag, " sk_req"}, bus.sk_req, 1);
                check({tag, " sk_idx"}, bus.sk_idx, c - 1);
                check({tag, " x_part"}, bus.x_part, int'(v.bits) & m);
                bus.sk_bit = v.bits[c-1];
            end else begin
                bus.sk_bit = 1'($urandom);
            end
            if (c == W + 1) check({tag, " busy in mul"}, bus.busy, 1);
            if (bus.done) begin
                done_n++;
                done_c = c;
                cx = bus.x; cp = bus.prod; cok = bus.ok; cic = bus.ic; cerr = bus.err;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        check({tag, " done count"}, done_n, 1);
        check({tag, " done cycle"}, done_c, 2 * W + 1);
        check({tag, " x"}, cx, v.x);
        check({tag, " prod"}, cp, v.prod);
        check({tag, " ok"}, cok, v.ok);
        check({tag, " ic"}, cic, v.ic);
        check({tag, " err"}, cerr, v.err);
        check({tag, " prod hold"}, bus.prod, v.prod);
        check({tag, " busy idle"}, bus.busy, 0);
    endtask

    initial begin
        // s, t, bits, pulses, x, prod, ok, ic, err
        tbl[0] = '{4'd3,  4'd5,  4'd1,  16'h0000, 4'd1,  4'd3,  1, 1, 0};
        tbl[1] = '{4'd5,  4'd2,  4'd1,  16'h0000, 4'd1,  4'd5,  0, 1, 1};
        tbl[2] = '{4'd3,  4'd5,  4'd1,  16'h0000, 4'd1,  4'd3,  1, 1, 0};
        tbl[3] = '{4'd15, 4'd2,  4'd15, 16'h0000, 4'd15, 4'd1,  1, 1, 0};
        tbl[4] = '{4'd3,  4'd0,  4'd9,  16'h0088, 4'd9,  4'd11, 0, 0, 0};
        tbl[5] = '{4'd7,  4'd8,  4'd6,  16'h0000, 4'd6,  4'd10, 0, 1, 1};
        tbl[6] = '{4'd0,  4'd1,  4'd5,  16'h0000, 4'd5,  4'd0,  1, 1, 0};
        tbl[7] = '{4'd4,  4'd15, 4'd12, 16'h0000, 4'd12, 4'd0,  1, 1, 0};

        bus.start = 0; bus.s = '0; bus.t = '0; bus.sk_bit = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset sk_req", bus.sk_req, 0);
        check("reset sk_idx", bus.sk_idx, 0);
        check("reset x_part", bus.x_part, 0);
        check("reset busy",   bus.busy, 0);
        check("reset done",   bus.done, 0);
        check("reset x",      bus.x, 0);
        check("reset prod",   bus.prod, 0);
        check("reset ok",     bus.ok, 0);
        check("reset ic",     bus.ic, 0);
        check("reset err",    bus.err, 0);
`ifdef SKW_STICKY_ERR_EN
        check("reset err_sticky", bus.err_sticky, 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run(tbl[i], $sformatf("tbl%0d", i));
`ifdef SKW_STICKY_ERR_EN
            check($sformatf("tbl%0d err_sticky", i), bus.err_sticky, (i >= 1) ? 1 : 0);
`endif
        end

        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] rs, rt, rb;
            logic [15:0]  rp;
            rs = W'($urandom);
            rt = W'($urandom);
            rb = W'($urandom);
            rp = 16'($urandom) & 16'h03FE;
            run(model(rs, rt, rb, rp), $sformatf("rnd%0d", i));
        end

        // Reset during the second COLLECT cycle discards the partial witness.
        @(negedge clk);
        bus.start = 1'b1; bus.s = 4'd3; bus.t = 4'd5;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.sk_bit = 1'b1;
        @(posedge clk); #1;
        check("midrst sk_idx before", bus.sk_idx, 1);
        check("midrst x_part before", bus.x_part, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst busy",   bus.busy, 0);
        check("midrst sk_req", bus.sk_req, 0);
        check("midrst x_part", bus.x_part, 0);
        check("midrst done",   bus.done, 0);
        check("midrst prod",   bus.prod, 0);
`ifdef SKW_STICKY_ERR_EN
        check("midrst err_sticky", bus.err_sticky, 0);
`endif
        begin
            int dn;
            dn = 0;
            for (int c = 0; c < 3 * W; c++) begin
                if (bus.done) dn++;
                @(posedge clk); #1;
            end
            check("midrst no done", dn, 0);
        end
        run(tbl[0], "after_rst");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
